// File: rtl/jk_pkg.sv
// Shared JK excitation codes and the q->n excitation helper for the JK modulo counter.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Code is {J,K}; toggle is never produced so external banks see only explicit set/reset.
    function automatic logic [1:0] jk_excite(input logic q, input logic n);
        logic [1:0] code;
        case ({q, n})
            2'b00:   code = JK_HOLD;
            2'b01:   code = JK_SET;
            2'b10:   code = JK_RESET;
            2'b11:   code = JK_HOLD;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with synchronous active-low clear taking priority over J/K.
module jk_cell
    import jk_pkg::*;
(
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic q_r;

    // JK storage: clear first, otherwise the JK truth table.
    always_ff @(posedge i_clk) begin
        if (!i_clear) begin
            q_r <= 1'b0;
        end else begin
            case ({i_j, i_k})
                JK_HOLD:   q_r <= q_r;
                JK_RESET:  q_r <= 1'b0;
                JK_SET:    q_r <= 1'b1;
                JK_TOGGLE: q_r <= ~q_r;
                default:   q_r <= q_r;
            endcase
        end
    end

    assign o_q = q_r;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter on a JK bit bank; exports J/K excitation for lock-step external banks.
// Define JK_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k,
    output logic             o_tc
);

    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};

    logic [WIDTH-1:0] q_s;
    logic [WIDTH:0]   wide_q_s;
    logic [WIDTH:0]   next_w_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             tc_event_s;
    logic             tc_r;

    assign wide_q_s = {1'b0, q_s};

    // Next-state selection: clear > load > count > hold, in WIDTH+1 bits.
    always_comb begin
        next_w_s   = wide_q_s;
        tc_event_s = 1'b0;
        if (!i_clear) begin
            next_w_s = ZERO_W;
        end else if (i_load) begin
            if ({1'b0, i_load_val} >= MOD_W) begin
                next_w_s = LAST_W;
            end else begin
                next_w_s = {1'b0, i_load_val};
            end
        end else if (i_en) begin
            if (i_up) begin
                if (wide_q_s >= LAST_W) begin
`ifdef JK_COUNTER_SAT_EN
                    next_w_s = LAST_W;
`else
                    next_w_s = ZERO_W;
`endif
                    tc_event_s = 1'b1;
                end else begin
                    next_w_s = wide_q_s + ONE_W;
                end
            end else begin
                if (wide_q_s == ZERO_W) begin
`ifdef JK_COUNTER_SAT_EN
                    next_w_s = ZERO_W;
`else
                    next_w_s = LAST_W;
`endif
                    tc_event_s = 1'b1;
                end else begin
                    next_w_s = wide_q_s - ONE_W;
                end
            end
        end else begin
            next_w_s = wide_q_s;
        end
    end

    // Keep the bank inside the count range even if the wide result ever overshoots.
    always_comb begin
        if (next_w_s > LAST_W) begin
            next_s = LAST_W[WIDTH-1:0];
        end else begin
            next_s = next_w_s[WIDTH-1:0];
        end
    end

    // Per-bit excitation from current Q to the selected next value.
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            {j_s[i], k_s[i]} = jk_excite(q_s[i], next_s[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_cell u_cell (
            .i_clk   (i_clk),
            .i_clear (i_clear),
            .i_j     (j_s[g]),
            .i_k     (k_s[g]),
            .o_q     (q_s[g])
        );
    end

    // Terminal-count pulse: one cycle after a wrap or a blocked saturating step.
    always_ff @(posedge i_clk) begin
        if (!i_clear) begin
            tc_r <= 1'b0;
        end else begin
            tc_r <= tc_event_s;
        end
    end

    assign o_count = q_s;
    assign o_j     = j_s;
    assign o_k     = k_s;
    assign o_tc    = tc_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10); honours JK_COUNTER_SAT_EN when defined.
module tb_jk_mod_counter;

    logic       i_clk = 1'b0;
    logic       i_clear;
    logic       i_en;
    logic       i_up;
    logic       i_load;
    logic [3:0] i_load_val;
    logic [3:0] o_count;
    logic [3:0] o_j;
    logic [3:0] o_k;
    logic       o_tc;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] ref_q = 4'b0000;
    logic       bank_en = 1'b0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .i_clk      (i_clk),
        .i_clear    (i_clear),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_count    (o_count),
        .o_j        (o_j),
        .o_k        (o_k),
        .o_tc       (o_tc)
    );

    always #5 i_clk = ~i_clk;

    // Reference JK bank driven only by the exported excitation.
    always @(posedge i_clk) begin
        ref_q <= (ref_q & ~o_k) | (o_j & ~ref_q);
    end

    // Every cycle: reference bank tracks o_count and toggle code never appears.
    always @(negedge i_clk) begin
        if (bank_en) begin
            n_cmp++;
            assert (o_count === ref_q) else begin
                n_err++;
                $error("FAIL bank_q: observed %b expected %b", o_count, ref_q);
            end
            n_cmp++;
            assert ((o_j & o_k) === 4'b0000) else begin
                n_err++;
                $error("FAIL no_toggle: observed j=%b k=%b expected no bit with both set", o_j, o_k);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic tc);
        chk({tag, "_count"}, {4'h0, o_count}, {4'h0, cnt});
        chk({tag, "_tc"}, {7'h00, o_tc}, {7'h00, tc});
    endtask

    task automatic chk_exc(input string tag, input logic [3:0] j, input logic [3:0] k);
        #1;
        chk({tag, "_j"}, {4'h0, o_j}, {4'h0, j});
        chk({tag, "_k"}, {4'h0, o_k}, {4'h0, k});
    endtask

    initial begin
        // 1. Reset held two edges with load and enable active.
        i_clear = 1'b0; i_en = 1'b1; i_up = 1'b1; i_load = 1'b1; i_load_val = 4'h5;
        tick();
        chk_state("rst1", 4'h0, 1'b0);
        chk_exc("rst1", 4'b0000, 4'b0000);
        bank_en = 1'b1;
        tick();
        chk_state("rst2", 4'h0, 1'b0);

        // 2. Up count through the wrap.
        i_clear = 1'b1; i_load = 1'b0; i_en = 1'b1; i_up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) chk_exc("up_at9", 4'b0000, 4'b1001);
            tick();
            chk_state("up", 4'(i % 10), (i == 10));
        end

        // 3. Down wrap from a loaded 0.
        i_load = 1'b1; i_load_val = 4'h0;
        tick();
        chk_state("ld0", 4'h0, 1'b0);
        i_load = 1'b0; i_up = 1'b0;
        chk_exc("dn_at0", 4'b1001, 4'b0000);
        tick();
        chk_state("dn_wrap", 4'h9, 1'b1);

        // 4. Load clamp, then clear beats load.
        i_load = 1'b1; i_load_val = 4'hE;
        chk_exc("clamp", 4'b0000, 4'b0000);
        tick();
        chk_state("clamp", 4'h9, 1'b0);
        i_clear = 1'b0;
        chk_exc("clr_ld", 4'b0000, 4'b1001);
        tick();
        chk_state("clr_ld", 4'h0, 1'b0);

        // 5. Hold at 6 while i_up toggles.
        i_clear = 1'b1; i_load_val = 4'h6;
        tick();
        chk_state("ld6", 4'h6, 1'b0);
        i_load = 1'b0; i_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_up = ~i_up;
            chk_exc("hold", 4'b0000, 4'b0000);
            tick();
            chk_state("hold", 4'h6, 1'b0);
        end

        // 6. Count up from 8 for three edges.
        i_load = 1'b1; i_load_val = 4'h8;
        tick();
        chk_state("ld8", 4'h8, 1'b0);
        i_load = 1'b0; i_en = 1'b1; i_up = 1'b1;
        chk_exc("up8", 4'b0001, 4'b0000);
        tick();
        chk_state("up8", 4'h9, 1'b0);
`ifdef JK_COUNTER_SAT_EN
        chk_exc("sat1", 4'b0000, 4'b0000);
        tick();
        chk_state("sat1", 4'h9, 1'b1);
        chk_exc("sat2", 4'b0000, 4'b0000);
        tick();
        chk_state("sat2", 4'h9, 1'b1);
`else
        chk_exc("wrap1", 4'b0000, 4'b1001);
        tick();
        chk_state("wrap1", 4'h0, 1'b1);
        chk_exc("wrap2", 4'b0001, 4'b0000);
        tick();
        chk_state("wrap2", 4'h1, 1'b0);
`endif

        // 7. Mid-count down step, then clear on a wrap edge suppresses o_tc.
        i_load = 1'b1; i_load_val = 4'h5;
        tick();
        i_load = 1'b0; i_up = 1'b0;
        chk_exc("dn5", 4'b0000, 4'b0001);
        tick();
        chk_state("dn5", 4'h4, 1'b0);
        i_load = 1'b1; i_load_val = 4'h9;
        tick();
        chk_state("ld9", 4'h9, 1'b0);
        i_load = 1'b0; i_up = 1'b1; i_clear = 1'b0;
        tick();
        chk_state("clr_wrap", 4'h0, 1'b0);
        i_clear = 1'b1; i_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
